// File: rtl/frame_dram_scheduler_if.sv
// frame_dram_scheduler_if: write stream, read requests and MIG user-interface signals
// shared by the frame buffer scheduler; slave is the scheduler, master its environment.
interface frame_dram_scheduler_if #(parameter int ADDR_W = 27);
    logic              calib_done_in;
    logic              wr_valid_in;
    logic              wr_ready_out;
    logic [127:0]      wr_data_in;
    logic              wr_tuser_in;
    logic              rd_valid_in;
    logic              rd_ready_out;
    logic              rd_tuser_in;
    logic [ADDR_W-1:0] app_addr_out;
    logic [2:0]        app_cmd_out;
    logic              app_en_out;
    logic              app_rdy_in;
    logic [127:0]      app_wdf_data_out;
    logic              app_wdf_wren_out;
    logic              app_wdf_end_out;
    logic [15:0]       app_wdf_mask_out;
    logic              app_wdf_rdy_in;
    logic              wr_frame_done_out;

    modport slave (
        input  calib_done_in, wr_valid_in, wr_data_in, wr_tuser_in, rd_valid_in, rd_tuser_in,
               app_rdy_in, app_wdf_rdy_in,
        output wr_ready_out, rd_ready_out, app_addr_out, app_cmd_out, app_en_out,
               app_wdf_data_out, app_wdf_wren_out, app_wdf_end_out, app_wdf_mask_out,
               wr_frame_done_out
    );
    modport master (
        output calib_done_in, wr_valid_in, wr_data_in, wr_tuser_in, rd_valid_in, rd_tuser_in,
               app_rdy_in, app_wdf_rdy_in,
        input  wr_ready_out, rd_ready_out, app_addr_out, app_cmd_out, app_en_out,
               app_wdf_data_out, app_wdf_wren_out, app_wdf_end_out, app_wdf_mask_out,
               wr_frame_done_out
    );
endinterface

// File: rtl/frame_dram_scheduler.sv
// frame_dram_scheduler: arbitrates camera writes and display reads onto one MIG port,
// generating wrapping/resyncing linear frame addresses.
module frame_dram_scheduler #(
    parameter int ADDR_W      = 27,
    parameter int FRAME_WORDS = 115200,
    parameter int ADDR_STEP   = 8,
    parameter int MAX_BURST   = 16
) (
    input logic clk_in,
    input logic rst_n_in,
    frame_dram_scheduler_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((FRAME_WORDS - 1) * ADDR_STEP);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
    localparam logic [1:0] S_CALIB = 2'd0, S_ARB = 2'd1, S_WR = 2'd2, S_RD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, app_addr_q, app_addr_d;
    logic [ADDR_W-1:0] used_addr, next_addr;
    logic [BW-1:0]     burst_q, burst_d;
    logic [127:0]      wdata_q, wdata_d;
    logic              last_wr_q, last_wr_d, app_en_q, app_en_d, wren_q, wren_d;
    logic              cmd_rd_q, cmd_rd_d, done_q, done_d;
    logic              arb, keep, prio_wr, grant_wr, grant_rd, grant, tuser;

    always_comb begin
        arb       = state_q == S_ARB && bus.calib_done_in;
        // zero burst count means nothing granted yet, so the side opposite last_wr wins
        keep      = burst_q != '0 && burst_q < BW'(MAX_BURST);
        prio_wr   = keep ? last_wr_q : !last_wr_q;
        grant_wr  = arb && bus.wr_valid_in && (!bus.rd_valid_in || prio_wr);
        grant_rd  = arb && bus.rd_valid_in && !grant_wr;
        grant     = grant_wr || grant_rd;
        tuser     = grant_wr ? bus.wr_tuser_in : bus.rd_tuser_in;
        used_addr = tuser ? '0 : grant_wr ? wr_addr_q : rd_addr_q;
        next_addr = used_addr == LAST_ADDR ? '0 : used_addr + STEP;
        app_en_d  = grant || (app_en_q && !bus.app_rdy_in);
        wren_d    = grant_wr || (wren_q && !bus.app_wdf_rdy_in);
        state_d   = state_q == S_CALIB ? (bus.calib_done_in ? S_ARB : S_CALIB)
                  : state_q == S_ARB ? (!bus.calib_done_in ? S_CALIB : grant_wr ? S_WR
                                        : grant_rd ? S_RD : S_ARB)
                  : (app_en_d || wren_d) ? state_q : S_ARB;
        wr_addr_d  = grant_wr ? next_addr : wr_addr_q;
        rd_addr_d  = grant_rd ? next_addr : rd_addr_q;
        app_addr_d = grant ? used_addr : app_addr_q;
        cmd_rd_d   = grant ? grant_rd : cmd_rd_q;
        wdata_d    = grant_wr ? bus.wr_data_in : wdata_q;
        last_wr_d  = grant ? grant_wr : last_wr_q;
        burst_d    = !grant ? burst_q
                   : grant_wr != last_wr_q ? BW'(1)
                   : burst_q == BW'(MAX_BURST) ? burst_q : burst_q + BW'(1);
        done_d     = grant_wr && (used_addr == LAST_ADDR || (bus.wr_tuser_in && wr_addr_q != '0));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= S_CALIB;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            app_addr_q <= '0;
            burst_q    <= '0;
            wdata_q    <= '0;
            last_wr_q  <= 1'b0;
            app_en_q   <= 1'b0;
            wren_q     <= 1'b0;
            cmd_rd_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            app_addr_q <= app_addr_d;
            burst_q    <= burst_d;
            wdata_q    <= wdata_d;
            last_wr_q  <= last_wr_d;
            app_en_q   <= app_en_d;
            wren_q     <= wren_d;
            cmd_rd_q   <= cmd_rd_d;
            done_q     <= done_d;
        end
    end

    assign bus.wr_ready_out      = grant_wr;
    assign bus.rd_ready_out      = grant_rd;
    assign bus.app_addr_out      = app_addr_q;
    assign bus.app_cmd_out       = {2'b00, cmd_rd_q};
    assign bus.app_en_out        = app_en_q;
    assign bus.app_wdf_data_out  = wdata_q;
    assign bus.app_wdf_wren_out  = wren_q;
    assign bus.app_wdf_end_out   = wren_q;
    assign bus.app_wdf_mask_out  = '0;
    assign bus.wr_frame_done_out = done_q;
endmodule
